// File: rtl/param_table_responder.sv
// Read-only parameter table served over a valid/ready request/response pair.
// Define PARAM_TABLE_DUMP_EN to enable the dump_start full-table dump mode.
module param_table_responder #(
  parameter logic        SOME_BIT_PARAM       = 1'b0,
  parameter logic [31:0] SOME_OTHER_INT_PARAM = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_idx,
  input  logic        dump_start,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic [15:0] rsp_count
);

  typedef enum logic [1:0] {IDLE, RESP, DUMP} state_t;

  state_t      r_state;
  logic [31:0] r_data;
  logic        r_err;
  logic        r_last;
  logic [15:0] r_count;
  logic        w_dump_go;
  logic        w_beat_done;

  // Returns {err, data} for one table index.
  function automatic logic [32:0] entry(input logic [2:0] idx);
    case (idx)
      3'd0:    entry = {1'b0, 31'd0, SOME_BIT_PARAM};
      3'd1:    entry = {1'b0, SOME_OTHER_INT_PARAM};
      3'd2:    entry = {1'b0, 32'h5041_524D};
      3'd3:    entry = {1'b0, 32'd5};
      3'd4:    entry = {1'b0, 24'd0, SOME_OTHER_INT_PARAM[15:8]};
      default: entry = {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef PARAM_TABLE_DUMP_EN
  logic [2:0] r_ptr;
  assign w_dump_go = (r_state == IDLE) && dump_start;
`else
  logic w_unused_dump_start;
  assign w_unused_dump_start = dump_start;
  assign w_dump_go = 1'b0;
`endif

  assign req_ready   = (r_state == IDLE) && !w_dump_go;
  assign rsp_valid   = (r_state != IDLE);
  assign w_beat_done = rsp_valid && rsp_ready;
  assign rsp_data    = r_data;
  assign rsp_err     = r_err;
  assign rsp_last    = r_last;
  assign rsp_count   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
      r_count <= 16'd0;
`ifdef PARAM_TABLE_DUMP_EN
      r_ptr   <= 3'd0;
`endif
    end else begin
      if (w_beat_done) r_count <= sat_inc(r_count);
      case (r_state)
        IDLE: begin
`ifdef PARAM_TABLE_DUMP_EN
          if (dump_start) begin
            r_state         <= DUMP;
            r_ptr           <= 3'd0;
            {r_err, r_data} <= entry(3'd0);
            r_last          <= 1'b0;
          end else
`endif
          if (req_valid) begin
            r_state         <= RESP;
            {r_err, r_data} <= entry(req_idx);
            r_last          <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
`ifdef PARAM_TABLE_DUMP_EN
        // Walk entries 0..4; each accepted beat loads the next entry.
        DUMP: begin
          if (rsp_ready) begin
            if (r_ptr == 3'd4) begin
              r_state <= IDLE;
            end else begin
              r_ptr           <= r_ptr + 3'd1;
              {r_err, r_data} <= entry(r_ptr + 3'd1);
              r_last          <= (r_ptr == 3'd3);
            end
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
